// File: rtl/matvec_engine.sv
// Matrix-vector engine: fetches M x N matrix and N-vector from RAM once, then
// computes y = M*v with one signed MAC per cycle and writes saturated rows back.
// Optional build macro MATVEC_RELU_EN clamps negative results to zero on write.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read pulse to RAM
// LOAD  | RAM outputs valid, capture operand copy
// MAC   | accumulate one element per cycle
// WRITE | write saturated row result
// DONE  | completion pulse
module matvec_engine #(
    parameter int DW   = 16,
    parameter int DIM  = 32,
    parameter int ACCW = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [5:0]              cfg_M,
    input  logic [5:0]              cfg_N,
    input  logic [19:0]             addr_matrix,
    input  logic [19:0]             addr_vector,
    input  logic [19:0]             addr_result,
    input  logic [DW*DIM*DIM-1:0]   matrix_in,
    input  logic [DW*DIM-1:0]       vector_in,
    output logic                    ram_read_matrix,
    output logic                    ram_read_vector,
    output logic [5:0]              ram_matrix_M,
    output logic [5:0]              ram_matrix_N,
    output logic [5:0]              ram_vector_L,
    output logic [19:0]             ram_address_matrix,
    output logic [19:0]             ram_address_vector,
    output logic                    ram_write,
    output logic [19:0]             ram_address,
    output logic [DW-1:0]           ram_data,
    output logic                    busy,
    output logic                    done,
    output logic                    saturated
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_MAC, S_WRITE, S_DONE
    } state_t;

    localparam logic signed [ACCW-1:0] SMAX = ACCW'((2**(DW-1)) - 1);
    localparam logic signed [ACCW-1:0] SMIN = -ACCW'(2**(DW-1));

    state_t state, state_nx;

    logic [5:0]  m_r, n_r, row, col;
    logic [19:0] am_r, av_r, ar_r;
    logic [DW*DIM*DIM-1:0] op_m;
    logic [DW*DIM-1:0]     op_v;
    logic signed [ACCW-1:0] acc;
    logic sat_r;

    logic [5:0] m_c, n_c;
    int m_idx;
    logic signed [DW-1:0]   m_el, v_el;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;
    logic [DW-1:0] res;
    logic clip;

    assign m_c = (cfg_M > 6'(DIM)) ? 6'(DIM) : cfg_M;
    assign n_c = (cfg_N > 6'(DIM)) ? 6'(DIM) : cfg_N;

    always_comb begin
        m_idx    = int'(row) * DIM + int'(col);
        m_el     = op_m[m_idx*DW +: DW];
        v_el     = op_v[int'(col)*DW +: DW];
        prod     = m_el * v_el;
        prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        clip     = 1'b0;
        res      = acc[DW-1:0];
        if (acc > SMAX) begin
            res  = {1'b0, {(DW-1){1'b1}}};
            clip = 1'b1;
        end else if (acc < SMIN) begin
            res  = {1'b1, {(DW-1){1'b0}}};
            clip = 1'b1;
        end
`ifdef MATVEC_RELU_EN
        if (res[DW-1]) res = '0;
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        ram_read_matrix = 1'b0;
        ram_read_vector = 1'b0;
        ram_write       = 1'b0;
        ram_address     = '0;
        ram_data        = '0;
        busy            = (state != S_IDLE);
        done            = 1'b0;
        saturated       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = (m_c == 6'd0 || n_c == 6'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                ram_read_matrix = 1'b1;
                ram_read_vector = 1'b1;
                state_nx        = S_LOAD;
            end
            S_LOAD:  state_nx = S_MAC;
            S_MAC: begin
                if (col == n_r - 6'd1) state_nx = S_WRITE;
            end
            S_WRITE: begin
                ram_write   = 1'b1;
                ram_address = ar_r + {14'd0, row};
                ram_data    = res;
                state_nx    = (row == m_r - 6'd1) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done      = 1'b1;
                saturated = sat_r;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r   <= '0;
            n_r   <= '0;
            am_r  <= '0;
            av_r  <= '0;
            ar_r  <= '0;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
            sat_r <= 1'b0;
            op_m  <= '0;
            op_v  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_r   <= m_c;
                        n_r   <= n_c;
                        am_r  <= addr_matrix;
                        av_r  <= addr_vector;
                        ar_r  <= addr_result;
                        sat_r <= 1'b0;
                    end
                end
                S_LOAD: begin
                    op_m <= matrix_in;
                    op_v <= vector_in;
                    row  <= '0;
                    col  <= '0;
                    acc  <= '0;
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    col <= col + 6'd1;
                end
                S_WRITE: begin
                    acc <= '0;
                    col <= '0;
                    if (clip) sat_r <= 1'b1;
                    if (row != m_r - 6'd1) row <= row + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // RAM sizing/addresses reflect the configuration latched at start
    assign ram_matrix_M       = m_r;
    assign ram_matrix_N       = n_r;
    assign ram_vector_L       = n_r;
    assign ram_address_matrix = am_r;
    assign ram_address_vector = av_r;

endmodule

// File: tb/tb_matvec_engine.sv
// Bench for matvec_engine: latency-accurate RAM model feeding the operand ports,
// and a write scoreboard fed by a reference model of y = M*v with saturation.
module tb_matvec_engine;
    localparam int DW  = 16;
    localparam int DIM = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [5:0]  cfg_M = '0, cfg_N = '0;
    logic [19:0] addr_matrix = '0, addr_vector = '0, addr_result = '0;
    logic [DW*DIM*DIM-1:0] matrix_in;
    logic [DW*DIM-1:0]     vector_in;
    logic ram_read_matrix, ram_read_vector, ram_write, busy, done, saturated;
    logic [5:0]  ram_matrix_M, ram_matrix_N, ram_vector_L;
    logic [19:0] ram_address_matrix, ram_address_vector, ram_address;
    logic [DW-1:0] ram_data;

    matvec_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_M(cfg_M), .cfg_N(cfg_N),
        .addr_matrix(addr_matrix), .addr_vector(addr_vector), .addr_result(addr_result),
        .matrix_in(matrix_in), .vector_in(vector_in),
        .ram_read_matrix(ram_read_matrix), .ram_read_vector(ram_read_vector),
        .ram_matrix_M(ram_matrix_M), .ram_matrix_N(ram_matrix_N), .ram_vector_L(ram_vector_L),
        .ram_address_matrix(ram_address_matrix), .ram_address_vector(ram_address_vector),
        .ram_write(ram_write), .ram_address(ram_address), .ram_data(ram_data),
        .busy(busy), .done(done), .saturated(saturated)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int mat[DIM][DIM];
    int vec[DIM];
    logic [DW*DIM*DIM-1:0] mat_pk = '0;
    logic [DW*DIM-1:0]     vec_pk = '0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    // RAM data is valid only in the cycle after the read pulse; garbage otherwise
    always @(posedge clk) begin
        matrix_in <= ram_read_matrix ? mat_pk : {(DIM*DIM){16'hA5C3}};
        vector_in <= ram_read_vector ? vec_pk : {DIM{16'h3C5A}};
    end

    always @(negedge clk) begin
        if (ram_read_matrix) rd_cnt++;
        if (ram_write) begin
            wr_cnt++;
            check("rw_excl", {62'd0, ram_read_matrix, ram_read_vector}, 64'd0);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(ram_address), 64'(mon_e.a));
                check("wr_data", 64'(ram_data), 64'(mon_e.d));
            end
        end
    end

    function automatic int clampd(input int x);
        return (x > DIM) ? DIM : x;
    endfunction

    task automatic clear_mats();
        for (int i = 0; i < DIM; i++) begin
            vec[i] = 0;
            for (int j = 0; j < DIM; j++) mat[i][j] = 0;
        end
    endtask

    task automatic pack_mats();
        for (int i = 0; i < DIM; i++) begin
            vec_pk[i*DW +: DW] = DW'(vec[i]);
            for (int j = 0; j < DIM; j++) mat_pk[(i*DIM+j)*DW +: DW] = DW'(mat[i][j]);
        end
    endtask

    task automatic push_expected(input int m, input int n, input logic [19:0] base,
                                 output logic esat);
        longint s;
        logic [15:0] d;
        esat = 1'b0;
        for (int i = 0; i < m; i++) begin
            s = 0;
            for (int j = 0; j < n; j++) s += longint'(mat[i][j]) * longint'(vec[j]);
            if (s > 32767) begin
                d = 16'h7FFF; esat = 1'b1;
            end else if (s < -32768) begin
                d = 16'h8000; esat = 1'b1;
            end else begin
                d = 16'(s);
            end
`ifdef MATVEC_RELU_EN
            if (d[15]) d = 16'h0000;
`endif
            exp_q.push_back('{a: 20'(base + 20'(i)), d: d});
        end
    endtask

    task automatic run_job(input int cm_in, input int cn_in, input logic [19:0] ar,
                           input int restart_at);
        int cm, cn, cyc, exp_cyc;
        logic esat, got_done, active;
        cm = clampd(cm_in);
        cn = clampd(cn_in);
        active = (cm != 0) && (cn != 0);
        pack_mats();
        exp_q.delete();
        push_expected(active ? cm : 0, cn, ar, esat);
        @(negedge clk);
        rd_cnt = 0;
        wr_cnt = 0;
        cfg_M = 6'(cm_in);
        cfg_N = 6'(cn_in);
        addr_matrix = 20'h01234;
        addr_vector = 20'h05678;
        addr_result = ar;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_start", {63'd0, busy}, 64'd1);
        if (active) begin
            check("fetch_rd", {62'd0, ram_read_matrix, ram_read_vector}, 64'd3);
            check("fetch_M", 64'(ram_matrix_M), 64'(cm));
            check("fetch_L", 64'(ram_vector_L), 64'(cn));
            check("fetch_am", 64'(ram_address_matrix), 64'h01234);
        end
        exp_cyc = active ? (2 + cm * (cn + 1) + 1) : 1;
        got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                start = (cyc == restart_at);
                if (cyc == restart_at) cfg_M = 6'd5;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", {63'd0, got_done}, 64'd1);
        check("done_cyc", 64'(cyc), 64'(exp_cyc));
        check("sat", {63'd0, saturated}, {63'd0, esat});
        check("busy_done", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("wr_cnt", 64'(wr_cnt), 64'(active ? cm : 0));
        check("rd_cnt", 64'(rd_cnt), 64'(active ? 1 : 0));
        check("q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {ram_read_matrix, ram_read_vector, ram_write, busy, done, saturated,
                    ram_matrix_M, ram_matrix_N, ram_vector_L, ram_address, ram_data}, 64'd0);
        check({tag, "_addr"}, {ram_address_matrix, ram_address_vector}, 64'd0);
    endtask

    initial begin
        logic esat;
        int cyc;
        clear_mats();
        pack_mats();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // basic 2x3
        mat[0][0] = 1; mat[0][1] = 2; mat[0][2] = 3;
        mat[1][0] = 4; mat[1][1] = 5; mat[1][2] = 6;
        vec[0] = 1; vec[1] = 1; vec[2] = 1;
        run_job(2, 3, 20'h00100, 0);

        // positive clip
        clear_mats();
        mat[0][0] = 300; mat[0][1] = 300; vec[0] = 300; vec[1] = 300;
        run_job(1, 2, 20'h00200, 0);

        // negative clip
        mat[0][0] = -300; mat[0][1] = -300;
        run_job(1, 2, 20'h00210, 0);

        // small negative result
        clear_mats();
        mat[0][0] = -2; vec[0] = 3;
        run_job(1, 1, 20'h00220, 0);

        // empty jobs
        run_job(0, 3, 20'h00010, 0);
        run_job(2, 0, 20'h00010, 0);

        // start while busy is ignored
        clear_mats();
        mat[0][0] = 1; mat[0][1] = 2; mat[0][2] = 3;
        mat[1][0] = 4; mat[1][1] = 5; mat[1][2] = 6;
        vec[0] = 7; vec[1] = -1; vec[2] = 2;
        run_job(2, 3, 20'h00300, 4);

        // address wrap
        clear_mats();
        mat[0][0] = 9; mat[1][0] = -9; vec[0] = 1;
        run_job(2, 1, 20'hFFFFF, 0);

        // full-size clamped random job
        for (int i = 0; i < DIM; i++) begin
            vec[i] = int'($urandom_range(0, 120)) - 60;
            for (int j = 0; j < DIM; j++) mat[i][j] = int'($urandom_range(0, 120)) - 60;
        end
        run_job(40, 63, 20'h02000, 0);

        // reset during row 1 MAC of a 3-row job
        clear_mats();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) mat[i][j] = i + j + 1;
        for (int j = 0; j < 4; j++) vec[j] = 2;
        pack_mats();
        exp_q.delete();
        push_expected(3, 4, 20'h00400, esat);
        @(negedge clk);
        wr_cnt = 0;
        cfg_M = 6'd3; cfg_N = 6'd4; addr_result = 20'h00400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 9) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        check("mid_reset_wr", 64'(wr_cnt), 64'd1);
        exp_q.delete();
        repeat (6) @(negedge clk);
        check("reset_hold_wr", 64'(wr_cnt), 64'd1);
        rst_n = 1'b1;
        run_job(3, 4, 20'h00400, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
